pll_lock_supervisor: RTL

//  Consumer-side supervisor for the system PLL. Runs on the 50 MHz board reference clock and samples the PLL
//  'locked' output through a synchronizer. Qualifies lock with a stability window and releases the

---
 rtl/pll_lock_supervisor_if.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL wrapper, the supervisor and the core's reset tree.
// master = supervisor side, slave = PLL/reset-tree side.
interface pll_lock_supervisor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             lock_ok;
    logic [CNT_W-1:0] loss_count;
    logic             timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst_n, lock_ok, loss_count, timeout_err
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst_n, lock_ok, loss_count, timeout_err
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock qualifier and system reset release on refclk; PLL_SUP_RETRY_EN enables
// re-arming the PLL (PLL_RST state, pll_rst pulse) on every lock timeout.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 5000000,
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned CNT_W            = 8
) (
    input  logic                         refclk,
    input  logic                         rst_n,
    pll_lock_supervisor_if.master        sup
);
    localparam int unsigned STAB_W = (STABLE_CYC > 1)       ? $clog2(STABLE_CYC)       : 1;
    localparam int unsigned TO_W   = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  LOSS_MAX  = '1;

    if (SYNC_STAGES < 2 || STABLE_CYC == 0 || LOCK_TIMEOUT_CYC == 0 ||
        PLL_RST_CYC == 0 || CNT_W == 0) begin : g_bad_cfg
        $error("pll_lock_supervisor: illegal parameter set");
    end

`ifdef PLL_SUP_RETRY_EN
    localparam int unsigned RST_W = (PLL_RST_CYC > 1) ? $clog2(PLL_RST_CYC) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, PLL_RST} state_t;
    logic [RST_W-1:0] rst_cnt;
    logic             pll_rst_q;
`else
    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;
`endif

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic [STAB_W-1:0]      stab_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic                   sys_rst_n_q;
    logic                   lock_ok_q;
    logic [CNT_W-1:0]       loss_q;
    logic                   timeout_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sup.pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LOCK;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            loss_q      <= '0;
            timeout_q   <= 1'b0;
`ifdef PLL_SUP_RETRY_EN
            rst_cnt     <= '0;
            pll_rst_q   <= 1'b0;
`endif
        end else begin
            case (state)
                WAIT_LOCK: begin
                    stab_cnt <= '0;
                    if (lk) begin
                        state  <= STABLE;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        timeout_q <= 1'b1;
`ifdef PLL_SUP_RETRY_EN
                        state     <= PLL_RST;
`endif
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state       <= RUN;
                        stab_cnt    <= '0;
                        sys_rst_n_q <= 1'b1;
                        lock_ok_q   <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state       <= WAIT_LOCK;
                        sys_rst_n_q <= 1'b0;
                        lock_ok_q   <= 1'b0;
                        if (loss_q != LOSS_MAX) begin
                            loss_q <= loss_q + CNT_W'(1);
                        end
                    end
                end
`ifdef PLL_SUP_RETRY_EN
                // First PLL_RST cycle raises the pulse; rst_cnt then times its width.
                PLL_RST: begin
                    if (!pll_rst_q) begin
                        pll_rst_q <= 1'b1;
                    end else if (rst_cnt == RST_LAST) begin
                        pll_rst_q <= 1'b0;
                        rst_cnt   <= '0;
                        state     <= WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
`endif
                default: state <= WAIT_LOCK;
            endcase
        end
    end

`ifdef PLL_SUP_RETRY_EN
    assign sup.pll_rst = pll_rst_q;
`else
    assign sup.pll_rst = 1'b0;
`endif
    assign sup.sys_rst_n   = sys_rst_n_q;
    assign sup.lock_ok     = lock_ok_q;
    assign sup.loss_count  = loss_q;
    assign sup.timeout_err = timeout_q;
endmodule
